// File: rtl/fsm_semaforo_pkg.sv
// Shared types, default timing and the lamp-consistency check for the
// N-direction traffic-light controller.
package fsm_semaforo_pkg;

   typedef enum logic [1:0] {ALLRED, GREEN, YELLOW, EMERG} state_t;

   localparam int DEF_N_DIR       = 2;
   localparam int DEF_W_TMR       = 8;
   localparam int DEF_T_GREEN_MIN = 4;
   localparam int DEF_T_GREEN_MAX = 10;
   localparam int DEF_T_YELLOW    = 3;
   localparam int DEF_T_ALLRED    = 2;

   // True when every direction shows exactly one lamp and at most one
   // direction is green or yellow. Vectors are zero-padded to 8 directions.
   function automatic logic lamps_ok(input logic [7:0] v, input logic [7:0] a,
                                     input logic [7:0] r, input int n);
      logic ok;
      int   lit;
      ok  = 1'b1;
      lit = 0;
      for (int i = 0; i < 8; i++) begin
         if (i < n) begin
            if ((int'(v[i]) + int'(a[i]) + int'(r[i])) != 1) ok = 1'b0;
            lit += int'(v[i]) + int'(a[i]);
         end
      end
      return ok && (lit <= 1);
   endfunction

endpackage

// File: rtl/fsm_semaforo_n_rr_sel.sv
// Round-robin selector: picks the next direction with demand after cur,
// and flags whether any direction other than cur is waiting.
module semaforo_rr_sel
   import fsm_semaforo_pkg::*;
#(
   parameter  int N_DIR = DEF_N_DIR,
   localparam int CW    = $clog2(N_DIR)
) (
   input  logic [N_DIR-1:0] T,
   input  logic [CW-1:0]    cur,
   output logic [CW-1:0]    next,
   output logic             other
);

   localparam int SW = CW + 1;

   function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] c, input int k);
      logic [SW-1:0] s;
      s = {1'b0, c} + SW'(k);
      if (s >= SW'(N_DIR)) s = s - SW'(N_DIR);
      return s[CW-1:0];
   endfunction

   logic [CW-1:0]    cand;
   logic [N_DIR-1:0] cur_oh;

   // Scan farthest-first so the nearest requesting index wins; with no
   // demand the default is simply the following direction.
   always_comb begin
      next = wrap_add(cur, 1);
      cand = '0;
      for (int k = N_DIR; k >= 1; k--) begin
         cand = wrap_add(cur, k);
         if (T[cand]) next = cand;
      end
   end

   always_comb begin
      cur_oh      = '0;
      cur_oh[cur] = 1'b1;
      other       = |(T & ~cur_oh);
   end

endmodule

// File: rtl/fsm_semaforo_n.sv
// N-direction traffic-light controller: round-robin green service with
// min/max green timing, fixed yellow and all-red phases, emergency hold.
module fsm_semaforo_n
   import fsm_semaforo_pkg::*;
#(
   parameter  int N_DIR       = DEF_N_DIR,
   parameter  int W_TMR       = DEF_W_TMR,
   parameter  int T_GREEN_MIN = DEF_T_GREEN_MIN,
   parameter  int T_GREEN_MAX = DEF_T_GREEN_MAX,
   parameter  int T_YELLOW    = DEF_T_YELLOW,
   parameter  int T_ALLRED    = DEF_T_ALLRED,
   localparam int CW          = $clog2(N_DIR)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_DIR-1:0] T,
   input  logic             E,
   output logic [N_DIR-1:0] verde,
   output logic [N_DIR-1:0] amarillo,
   output logic [N_DIR-1:0] rojo,
   output logic [CW-1:0]    dir_act,
   output logic             emerg_act
);

   if (N_DIR < 2 || N_DIR > 8) begin : g_bad_ndir
      $error("fsm_semaforo_n: N_DIR must be in 2..8");
   end
   if (T_GREEN_MIN < 1 || T_GREEN_MIN > T_GREEN_MAX ||
       T_GREEN_MAX >= (2 ** W_TMR)) begin : g_bad_green
      $error("fsm_semaforo_n: need 1 <= T_GREEN_MIN <= T_GREEN_MAX < 2**W_TMR");
   end
   if (T_YELLOW < 1 || T_ALLRED < 1) begin : g_bad_fixed
      $error("fsm_semaforo_n: T_YELLOW and T_ALLRED must be at least 1");
   end

   state_t           state_q, state_d;
   logic [CW-1:0]    cur_q, cur_d;
   logic [W_TMR-1:0] tmr_q, tmr_d;
   logic [CW-1:0]    next_dir;
   logic             other_dem;
   logic [N_DIR-1:0] cur_oh;

   semaforo_rr_sel #(.N_DIR(N_DIR)) u_sel (
      .T     (T),
      .cur   (cur_q),
      .next  (next_dir),
      .other (other_dem)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ALLRED;
         cur_q   <= CW'(N_DIR - 1);
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         tmr_q   <= tmr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      unique case (state_q)
         ALLRED: begin
            if (tmr_q == W_TMR'(T_ALLRED - 1)) begin
               if (E) begin
                  state_d = EMERG;
               end else begin
                  state_d = GREEN;
                  cur_d   = next_dir;
               end
            end
         end
         GREEN: begin
            // Emergency cuts green short; otherwise only hand over when
            // someone else is waiting and the relevant time bound is met.
            if (E ||
                (other_dem && tmr_q >= W_TMR'(T_GREEN_MIN - 1) && !T[cur_q]) ||
                (other_dem && tmr_q >= W_TMR'(T_GREEN_MAX - 1))) begin
               state_d = YELLOW;
            end
         end
         YELLOW: begin
            if (tmr_q == W_TMR'(T_YELLOW - 1)) state_d = ALLRED;
         end
         EMERG: begin
            if (!E) state_d = ALLRED;
         end
         default: state_d = ALLRED;
      endcase

      if (state_d != state_q) tmr_d = '0;
      else if (&tmr_q)        tmr_d = tmr_q;
      else                    tmr_d = tmr_q + 1'b1;
   end

   always_comb begin
      cur_oh        = '0;
      cur_oh[cur_q] = 1'b1;
      verde         = (state_q == GREEN)  ? cur_oh : '0;
      amarillo      = (state_q == YELLOW) ? cur_oh : '0;
      rojo          = ~(verde | amarillo);
      dir_act       = cur_q;
      emerg_act     = (state_q == EMERG);
   end

   lamp_check: assert property (@(posedge clk) disable iff (!reset)
      lamps_ok(8'(verde), 8'(amarillo), 8'(rojo), N_DIR));

endmodule
